// File: rtl/vga_pkg.sv
// Shared VGA geometry, sprite scaling constants and the timing bus type.
// CHAR_TRANSPARENT_EN (optional) enables CHAR_KEY_COLOUR keying in sprites.
package vga_pkg;

    localparam logic [10:0] HOR_TOTAL_TIME = 11'd1344;

    localparam logic [10:0] CHAR_X_HOST  = 11'd96;
    localparam logic [10:0] CHAR_Y_HOST  = 11'd193;
    localparam logic [10:0] CHAR_X_GUEST = 11'd608;
    localparam logic [10:0] CHAR_Y_GUEST = 11'd193;
    localparam logic [10:0] CHAR_LENGTH  = 11'd320;
    localparam logic [10:0] CHAR_HEIGHT  = 11'd320;

    localparam int CHAR_SIZE  = 32;
    localparam int CHAR_SCALE = int'(CHAR_LENGTH) / CHAR_SIZE;
    localparam int SUB_W      = $clog2(CHAR_SCALE);
    localparam int IDX_W      = $clog2(CHAR_SIZE);

    localparam logic [11:0] CHAR_KEY_COLOUR = 12'hF0F;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

    function automatic logic in_span(
        input logic [10:0] v,
        input logic [10:0] lo,
        input logic [10:0] len
    );
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage

// File: rtl/char_scale_ctr.sv
// Divide-by-CHAR_SCALE sub counter feeding a CHAR_SIZE source index.
// Clear has priority over enable; the index wraps rather than overflowing.
module char_scale_ctr
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SUB_W-1:0] sub,
    output logic [IDX_W-1:0] idx
);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CHAR_SCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAR_SIZE - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub <= '0;
            idx <= '0;
        end else if (clr) begin
            sub <= '0;
            idx <= '0;
        end else if (en) begin
            if (sub == SUB_LAST) begin
                sub <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_char_sprite.sv
// Overlays host/guest x10-scaled 32x32 ROM sprites on the VGA stream.
// Optional macro CHAR_TRANSPARENT_EN keys out CHAR_KEY_COLOUR pixels.
module draw_char_sprite
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    vga_bus_t         bus_in, bus_d1, bus_d2, bus_mux, bus_q;
    logic             in_host, in_guest, in_win;
    logic             h_end, v_clr, v_en, v_valid;
    logic             win_d1, win_d2;
    logic [SUB_W-1:0] hsub, vsub;
    logic [IDX_W-1:0] col, row;
    logic [11:0]      sprite_rgb;

    always_comb begin
        bus_in.hcount = hcount_in;
        bus_in.vcount = vcount_in;
        bus_in.hsync  = hsync_in;
        bus_in.vsync  = vsync_in;
        bus_in.hblnk  = hblnk_in;
        bus_in.vblnk  = vblnk_in;
        bus_in.rgb    = rgb_in;

        in_host = in_span(hcount_in, CHAR_X_HOST, CHAR_LENGTH)
               && in_span(vcount_in, CHAR_Y_HOST, CHAR_HEIGHT)
               && !hblnk_in && !vblnk_in;
        in_guest = in_span(hcount_in, CHAR_X_GUEST, CHAR_LENGTH)
                && in_span(vcount_in, CHAR_Y_GUEST, CHAR_HEIGHT)
                && !hblnk_in && !vblnk_in;
        in_win = in_host | in_guest;

        h_end = (hcount_in == HOR_TOTAL_TIME - 11'd1);
        v_clr = h_end && (vcount_in == CHAR_Y_HOST - 11'd1);
        v_en  = h_end && in_span(vcount_in, CHAR_Y_HOST, CHAR_HEIGHT);
    end

    char_scale_ctr u_hscale (
        .clk (clk),
        .rst (rst),
        .clr (!in_win),
        .en  (in_win),
        .sub (hsub),
        .idx (col)
    );

    char_scale_ctr u_vscale (
        .clk (clk),
        .rst (rst),
        .clr (v_clr),
        .en  (v_en),
        .sub (vsub),
        .idx (row)
    );

    // v_valid blocks drawing until a full sprite height can be counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_valid <= 1'b0;
        end else if (h_end) begin
            if (vcount_in == CHAR_Y_HOST - 11'd1)
                v_valid <= 1'b1;
            else if (vcount_in == CHAR_Y_HOST + CHAR_HEIGHT - 11'd1)
                v_valid <= 1'b0;
        end
    end

    always_comb begin
        sprite_rgb = rom_data;
`ifdef CHAR_TRANSPARENT_EN
        if (rom_data == CHAR_KEY_COLOUR)
            sprite_rgb = bus_d2.rgb;
`endif
        bus_mux = bus_d2;
        if (win_d2)
            bus_mux.rgb = sprite_rgb;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            win_d1   <= 1'b0;
            win_d2   <= 1'b0;
            bus_d1   <= '0;
            bus_d2   <= '0;
            bus_q    <= '0;
        end else begin
            if (in_win && v_valid)
                rom_addr <= {in_guest, row, col};
            win_d1 <= in_win & v_valid;
            win_d2 <= win_d1;
            bus_d1 <= bus_in;
            bus_d2 <= bus_d1;
            bus_q  <= bus_mux;
        end
    end

    assign hcount_out = bus_q.hcount;
    assign vcount_out = bus_q.vcount;
    assign hsync_out  = bus_q.hsync;
    assign vsync_out  = bus_q.vsync;
    assign hblnk_out  = bus_q.hblnk;
    assign vblnk_out  = bus_q.vblnk;
    assign rgb_out    = bus_q.rgb;

    // Scaler phases are internal only; keep them referenced.
    logic unused_ok;
    assign unused_ok = ^{hsub, vsub};

endmodule

// File: tb/tb_draw_char_sprite.sv
// Scoreboard bench for draw_char_sprite with table-driven sprite points.
// Compressed lines (only hcount 1343) keep whole frames short.
module tb_draw_char_sprite;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0;
    logic        hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    always #5 clk = ~clk;

    draw_char_sprite dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    typedef struct {
        vga_bus_t bus;
        string    tag;
    } sb_t;

    typedef struct {
        int          x;
        int          y;
        logic [10:0] addr;
        bit          sprite;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];
    sb_t  q [$];

    int          checks = 0;
    int          errors = 0;
    bit          m_vvalid = 0;
    bit          key_at0 = 0;
    bit          vec_en = 0;
    logic [10:0] exp_addr = '0;

    function automatic logic [11:0] rom_val(input logic [10:0] a);
        if (key_at0 && a == 11'd0)
            return 12'hF0F;
        return {1'b1, a};
    endfunction

    function automatic logic [11:0] shown(
        input logic [11:0] pix,
        input logic [11:0] bg
    );
`ifdef CHAR_TRANSPARENT_EN
        if (pix == 12'hF0F)
            return bg;
`endif
        if (bg == 12'hFFF && pix == 12'hFFF)
            return pix;
        return pix;
    endfunction

    always @(posedge clk)
        rom_data <= rom_val(rom_addr);

    function automatic vga_bus_t dut_bus();
        vga_bus_t b;
        b.hcount = hcount_out;
        b.vcount = vcount_out;
        b.hsync  = hsync_out;
        b.vsync  = vsync_out;
        b.hblnk  = hblnk_out;
        b.vblnk  = vblnk_out;
        b.rgb    = rgb_out;
        return b;
    endfunction

    task automatic check_bus(input string tag, input vga_bus_t e);
        vga_bus_t a;
        a = dut_bus();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, a, e);
        end
    endtask

    task automatic check_addr(input string tag, input logic [10:0] e);
        checks++;
        if (rom_addr !== e) begin
            errors++;
            $display("FAIL %s rom_addr: got %0d expected %0d",
                     tag, rom_addr, e);
        end
    endtask

    task automatic step(
        input int          x,
        input int          y,
        input logic        hs,
        input logic        vs,
        input logic        hb,
        input logic        vb,
        input logic [11:0] rgb
    );
        vga_bus_t e;
        bit       ih, ig, sp;
        int       vi;
        string    tag;
        sb_t      s;
        vi  = -1;
        tag = "bus";
        hcount_in = 11'(x);
        vcount_in = 11'(y);
        hsync_in  = hs;
        vsync_in  = vs;
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        ih = x >= 96 && x <= 415 && y >= 193 && y <= 512 && !hb && !vb;
        ig = x >= 608 && x <= 927 && y >= 193 && y <= 512 && !hb && !vb;
        sp = (ih || ig) && m_vvalid;
        if (sp)
            exp_addr = {ig, 5'((y - 193) / 10),
                        5'((x - (ig ? 608 : 96)) / 10)};
        e.hcount = 11'(x);
        e.vcount = 11'(y);
        e.hsync  = hs;
        e.vsync  = vs;
        e.hblnk  = hb;
        e.vblnk  = vb;
        e.rgb    = sp ? shown(rom_val(exp_addr), rgb) : rgb;
        if (vec_en) begin
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].x == x && vecs[i].y == y) begin
                    vi  = i;
                    tag = $sformatf("vec(%0d,%0d)", x, y);
                    e.rgb = vecs[i].sprite ?
                            shown(rom_val(vecs[i].addr), rgb) : rgb;
                end
            end
        end
        q.push_back('{bus: e, tag: tag});
        if (x == 1343) begin
            if (y == 192)
                m_vvalid = 1;
            else if (y == 512)
                m_vvalid = 0;
        end
        @(posedge clk);
        #1;
        if (vi >= 0 && vecs[vi].sprite)
            check_addr(tag, vecs[vi].addr);
        else
            check_addr("track", exp_addr);
        if (q.size() == 3) begin
            s = q.pop_front();
            check_bus(s.tag, s.bus);
        end
    endtask

    task automatic pulse_reset(input int n);
        sb_t z;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_bus("reset", '0);
            check_addr("reset", 11'd0);
        end
        rst = 1'b0;
        q.delete();
        z.bus = '0;
        z.tag = "post_reset";
        q.push_back(z);
        q.push_back(z);
        exp_addr = '0;
        m_vvalid = 0;
    endtask

    task automatic line(input int y, input bit full, input int rst_x);
        int lo;
        logic [11:0] c;
        lo = full ? 0 : 1343;
        for (int x = lo; x < 1344; x++) begin
            c = 12'($urandom);
            if (x == 96 && y == 193)
                c = 12'h123;
            step(x, y, x >= 1048 && x < 1184, y >= 771 && y < 777,
                 x >= 1024, y >= 768, c);
            if (x == rst_x)
                pulse_reset(3);
        end
    endtask

    task automatic frame(input int rst_y, input int rst_x);
        bit full;
        for (int y = 0; y < 806; y++) begin
            full = (y == rst_y) || y == 193 || y == 203
                || y == 512 || y == 513;
            line(y, full, (y == rst_y) ? rst_x : -1);
        end
    endtask

    initial begin
        vecs[0] = '{x: 96,  y: 193, addr: 11'd0,    sprite: 1};
        vecs[1] = '{x: 105, y: 193, addr: 11'd0,    sprite: 1};
        vecs[2] = '{x: 106, y: 193, addr: 11'd1,    sprite: 1};
        vecs[3] = '{x: 415, y: 193, addr: 11'd31,   sprite: 1};
        vecs[4] = '{x: 416, y: 193, addr: 11'd31,   sprite: 0};
        vecs[5] = '{x: 608, y: 193, addr: 11'd1024, sprite: 1};
        vecs[6] = '{x: 96,  y: 203, addr: 11'd32,   sprite: 1};
        vecs[7] = '{x: 96,  y: 512, addr: 11'd992,  sprite: 1};
        vecs[8] = '{x: 96,  y: 513, addr: 11'd992,  sprite: 0};

        pulse_reset(3);

        vec_en = 1;
        frame(-1, -1);

        vec_en = 0;
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1342), $urandom_range(0, 191),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 12'($urandom));

        frame(300, 200);

        vec_en  = 1;
        key_at0 = 1;
        frame(-1, -1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
